// File: rtl/ucsbece154b_icache_pkg.sv
// ucsbece154b_icache_pkg
//   Shared definitions for the instruction cache: controller state encoding
//   and the NOP word returned to fetch whenever the cache cannot supply an
//   instruction.
package ucsbece154b_icache_pkg;

   typedef enum logic [1:0] {
      LOOKUP  = 2'd0,
      REQUEST = 2'd1,
      REFILL  = 2'd2
   } icache_state_t;

   // addi x0, x0, 0
   localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/ucsbece154b_icache.sv
// ucsbece154b_icache
//   Direct-mapped, blocking instruction cache between instruction memory and
//   the fetch stage. Hits return the instruction in the same cycle; a miss
//   issues a single-cycle line request and refills the whole line from a
//   word-serial memory port before lookup resumes.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   PCF_i             : fetch PC (bits [1:0] ignored)
//   InstrF_o          : instruction at PCF_i when ReadyF_o=1, else NOP
//   ReadyF_o          : 1 = hit, InstrF_o valid this cycle
//   MemReadRequest_o  : one-cycle refill request pulse
//   MemReadAddress_o  : line-aligned refill address (0 while in LOOKUP)
//   MemDataReady_i    : one refill word valid on MemDataIn_i
//   MemDataIn_i       : refill word, ascending order from word 0
module ucsbece154b_icache
   import ucsbece154b_icache_pkg::*;
#(
   parameter int NUM_SETS    = 8,
   parameter int BLOCK_WORDS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PCF_i,
   output logic [31:0] InstrF_o,
   output logic        ReadyF_o,
   output logic        MemReadRequest_o,
   output logic [31:0] MemReadAddress_o,
   input  logic        MemDataReady_i,
   input  logic [31:0] MemDataIn_i
);

   localparam int WORD_W  = $clog2(BLOCK_WORDS);
   localparam int SET_W   = $clog2(NUM_SETS);
   localparam int TAG_W   = 30 - WORD_W - SET_W;
   localparam int SET_LSB = 2 + WORD_W;
   localparam int TAG_LSB = SET_LSB + SET_W;
   localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(BLOCK_WORDS - 1);

   icache_state_t r_state, w_next;

   logic [NUM_SETS-1:0] r_valid;
   logic [TAG_W-1:0]    r_tag  [NUM_SETS];
   logic [31:0]         r_data [NUM_SETS][BLOCK_WORDS];

   logic [WORD_W-1:0]   r_cnt;
   logic [TAG_W-1:0]    r_miss_tag;
   logic [SET_W-1:0]    r_miss_set;

   logic [WORD_W-1:0]   w_word;
   logic [SET_W-1:0]    w_set;
   logic [TAG_W-1:0]    w_tag;
   logic                w_hit;
   logic                w_fill;
   logic                w_fill_last;
   logic [31:0]         w_line_addr;
   logic                w_unused_pc;

   assign w_word = PCF_i[2 +: WORD_W];
   assign w_set  = PCF_i[SET_LSB +: SET_W];
   assign w_tag  = PCF_i[TAG_LSB +: TAG_W];
   assign w_hit  = r_valid[w_set] && (r_tag[w_set] == w_tag);

   // byte offset never affects the lookup
   assign w_unused_pc = &{1'b0, PCF_i[1:0]};

   // refill words are only taken while actually refilling
   assign w_fill      = (r_state == REFILL) && MemDataReady_i;
   assign w_fill_last = w_fill && (r_cnt == LAST_WORD);
   assign w_line_addr = {r_miss_tag, r_miss_set, {(WORD_W + 2){1'b0}}};

   always_ff @(posedge clk) begin
      if (reset) r_state <= LOOKUP;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next           = r_state;
      ReadyF_o         = 1'b0;
      InstrF_o         = NOP;
      MemReadRequest_o = 1'b0;
      MemReadAddress_o = 32'h0;
      case (r_state)
         LOOKUP: begin
            if (w_hit) begin
               ReadyF_o = 1'b1;
               InstrF_o = r_data[w_set][w_word];
            end else begin
               w_next = REQUEST;
            end
         end
         REQUEST: begin
            MemReadRequest_o = 1'b1;
            MemReadAddress_o = w_line_addr;
            w_next           = REFILL;
         end
         REFILL: begin
            MemReadAddress_o = w_line_addr;
            if (w_fill_last) w_next = LOOKUP;
         end
         default: w_next = LOOKUP;
      endcase
   end

   // control state: valid bits, word counter, latched miss line
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid    <= '0;
         r_cnt      <= '0;
         r_miss_tag <= '0;
         r_miss_set <= '0;
      end else begin
         case (r_state)
            LOOKUP: begin
               if (!w_hit) begin
                  r_miss_tag <= w_tag;
                  r_miss_set <= w_set;
               end
            end
            REQUEST: begin
               r_cnt <= '0;
               // the line is being overwritten, so it must not hit until
               // the last word lands
               r_valid[r_miss_set] <= 1'b0;
            end
            REFILL: begin
               if (w_fill) begin
                  r_cnt <= r_cnt + 1'b1;
                  if (w_fill_last) r_valid[r_miss_set] <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // storage arrays carry no reset; valid bits alone qualify them
   always_ff @(posedge clk) begin
      if (!reset && w_fill) begin
         r_data[r_miss_set][r_cnt] <= MemDataIn_i;
         if (w_fill_last) r_tag[r_miss_set] <= r_miss_tag;
      end
   end

endmodule

// File: tb/tb_ucsbece154b_icache.sv
module tb_ucsbece154b_icache;
   import ucsbece154b_icache_pkg::*;

   localparam int BW = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] PCF_i;
   logic [31:0] InstrF_o;
   logic        ReadyF_o;
   logic        MemReadRequest_o;
   logic [31:0] MemReadAddress_o;
   logic        MemDataReady_i;
   logic [31:0] MemDataIn_i;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] exp_addr_q [$];
   logic [31:0] exp_instr_q [$];

   ucsbece154b_icache #(.NUM_SETS(8), .BLOCK_WORDS(BW)) dut (
      .clk              (clk),
      .reset            (reset),
      .PCF_i            (PCF_i),
      .InstrF_o         (InstrF_o),
      .ReadyF_o         (ReadyF_o),
      .MemReadRequest_o (MemReadRequest_o),
      .MemReadAddress_o (MemReadAddress_o),
      .MemDataReady_i   (MemDataReady_i),
      .MemDataIn_i      (MemDataIn_i)
   );

   always #5 clk = ~clk;

   // backing memory contents
   function automatic logic [31:0] memw(input logic [31:0] a);
      if (a[31:4] == 28'h0)      return 32'hA0 + {30'h0, a[3:2]};
      else if (a[31:4] == 28'h8) return 32'hB0 + {30'h0, a[3:2]};
      else                       return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_ready"}, {31'h0, ReadyF_o}, 32'h0);
      chk({nm, "_instr"}, InstrF_o, NOP);
      chk({nm, "_req"}, {31'h0, MemReadRequest_o}, 32'h0);
      chk({nm, "_addr"}, MemReadAddress_o, 32'h0);
   endtask

   // drive a PC expected to miss; schedule the line request it must cause
   task automatic miss(input logic [31:0] pc);
      PCF_i = pc;
      exp_addr_q.push_back({pc[31:4], 4'h0});
      #1;
      chk("miss_ready", {31'h0, ReadyF_o}, 32'h0);
      chk("miss_instr", InstrF_o, NOP);
   endtask

   // drive a PC expected to hit in the same cycle
   task automatic hit(input logic [31:0] pc);
      logic [31:0] e;
      PCF_i = pc;
      exp_instr_q.push_back(memw(pc));
      #1;
      chk("hit_ready", {31'h0, ReadyF_o}, 32'h1);
      chk("hit_noreq", {31'h0, MemReadRequest_o}, 32'h0);
      e = exp_instr_q.pop_front();
      chk("hit_instr", InstrF_o, e);
      tick();
   endtask

   // memory responder: wait for the request, check it, return the line.
   // redirect_at / abort_at = BW disables that event.
   task automatic refill(input int gap, input int redirect_at,
                         input logic [31:0] redirect_pc, input int abort_at);
      int          waited;
      logic [31:0] ea;
      waited = 0;
      ea = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 32'hDEAD_BEEF;
      while (!MemReadRequest_o && waited < 40) begin
         tick();
         waited++;
      end
      if (!MemReadRequest_o) begin
         chk("req_timeout", 32'h0, 32'h1);
         return;
      end
      chk("req_latency", waited, 1);
      chk("req_addr", MemReadAddress_o, ea);
      chk("req_ready", {31'h0, ReadyF_o}, 32'h0);
      tick();
      chk("req_pulse", {31'h0, MemReadRequest_o}, 32'h0);
      for (int w = 0; w < BW; w++) begin
         repeat (gap) tick();
         MemDataReady_i = 1'b1;
         MemDataIn_i    = memw(ea + 32'(4 * w));
         if (w == abort_at) begin
            reset = 1'b1;
            tick();
            reset          = 1'b0;
            MemDataReady_i = 1'b0;
            return;
         end
         if (w == redirect_at) PCF_i = redirect_pc;
         tick();
         MemDataReady_i = 1'b0;
         if (w < BW - 1) chk("refill_ready", {31'h0, ReadyF_o}, 32'h0);
      end
   endtask

   initial begin
      reset = 1'b1;
      PCF_i = 32'h0;
      MemDataReady_i = 1'b0;
      MemDataIn_i = 32'h0;
      tick();
      tick();
      chk_reset_outputs("reset");
      reset = 1'b0;

      // cold miss then whole-line hits
      miss(32'h0);
      refill(0, BW, 32'h0, BW);
      hit(32'h0);
      hit(32'h4);
      hit(32'h8);
      hit(32'hC);

      // conflicting tag in set 0 evicts, and back again
      miss(32'h80);
      refill(0, BW, 32'h0, BW);
      hit(32'h80);
      hit(32'h8C);
      miss(32'h0);
      refill(0, BW, 32'h0, BW);
      hit(32'h4);

      // evict again, then gapped refill with a redirect mid-refill
      miss(32'h80);
      refill(0, BW, 32'h0, BW);
      hit(32'h84);
      miss(32'h0);
      refill(3, 1, 32'h40, BW);
      exp_addr_q.push_back(32'h40);
      #1;
      chk("redir_ready", {31'h0, ReadyF_o}, 32'h0);
      refill(0, BW, 32'h0, BW);
      hit(32'h40);
      hit(32'h0);
      hit(32'h4);
      hit(32'h8);
      hit(32'hC);

      // reset after two words of a refill
      miss(32'h100);
      refill(1, BW, 32'h0, 2);
      PCF_i = 32'h0;
      #1;
      chk_reset_outputs("midreset");
      exp_addr_q.push_back(32'h0);
      refill(0, BW, 32'h0, BW);
      hit(32'h0);
      hit(32'hC);

      // set 3, nonzero word offset and byte offset bits
      miss(32'h1234);
      refill(2, BW, 32'h0, BW);
      hit(32'h1234);
      hit(32'h1233);

      // line 0 must still be resident after unrelated refills
      hit(32'h8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
